// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port memory arbiter: requester IDs and FSM state.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        REQ_H    = 2'd0,
        REQ_D    = 2'd1,
        REQ_I    = 2'd2,
        REQ_NONE = 2'd3
    } req_id_t;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker between D and I; the parent registers rr_next.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    d_req,
    input  logic    i_req,
    input  req_id_t rr_last,
    output req_id_t pick,
    output req_id_t rr_next
);

    always_comb begin
        pick = REQ_NONE;
        if (d_req && i_req) begin
            pick = (rr_last == REQ_D) ? REQ_I : REQ_D;
        end else if (d_req) begin
            pick = REQ_D;
        end else if (i_req) begin
            pick = REQ_I;
        end
        rr_next = (pick == REQ_NONE) ? rr_last : pick;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous word RAM among host loader (H), CPU data (D) and CPU fetch (I).
// H has priority and may lock the memory; a starvation counter bounds D/I lockout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output arb_state_t        dbg_state
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    req_id_t          rr_last_q, rr_last_d;
    logic             rsp_valid_q, rsp_valid_d;
    req_id_t          rsp_owner_q, rsp_owner_d;

    req_id_t          di_pick;
    req_id_t          rr_next;
    req_id_t          winner;
    logic             di_pend;
    logic             starve;
    logic             di_gnt;

    rr_pick2 u_rr_pick2 (
        .d_req   (d_req),
        .i_req   (i_req),
        .rr_last (rr_last_q),
        .pick    (di_pick),
        .rr_next (rr_next)
    );

    // Starvation beats H in both states; otherwise H wins, and D/I only get OPEN cycles.
    always_comb begin
        di_pend = d_req || i_req;
        starve  = (wait_cnt_q == CNT_MAX) && di_pend;
        winner  = REQ_NONE;
        if (!reset_n) begin
            winner = REQ_NONE;
        end else if (starve) begin
            winner = di_pick;
        end else if (h_req) begin
            winner = REQ_H;
        end else if (state_q == ST_OPEN) begin
            winner = di_pick;
        end
    end

    assign h_gnt  = (winner == REQ_H);
    assign d_gnt  = (winner == REQ_D);
    assign i_gnt  = (winner == REQ_I);
    assign di_gnt = d_gnt || i_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (winner)
            REQ_H: begin
                mem_en    = 1'b1;
                mem_we    = h_we;
                mem_addr  = h_addr;
                mem_wdata = h_wdata;
            end
            REQ_D: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            REQ_I: begin
                mem_en    = 1'b1;
                mem_addr  = i_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OPEN:   if (h_gnt && h_lock) state_d = ST_LOCKED;
            ST_LOCKED: if (!h_lock)         state_d = ST_OPEN;
            default:                        state_d = ST_OPEN;
        endcase

        if (di_gnt || !di_pend) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        rr_last_d   = di_gnt ? rr_next : rr_last_q;
        rsp_valid_d = mem_en && !mem_we;
        rsp_owner_d = winner;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OPEN;
            wait_cnt_q  <= '0;
            rr_last_q   <= REQ_D;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= REQ_NONE;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rr_last_q   <= rr_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign h_rvalid  = rsp_valid_q && (rsp_owner_q == REQ_H);
    assign d_rvalid  = rsp_valid_q && (rsp_owner_q == REQ_D);
    assign i_rvalid  = rsp_valid_q && (rsp_owner_q == REQ_I);

    // Read data is zeroed outside its valid pulse so idle outputs stay quiet.
    assign h_rdata   = h_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant checks per cycle, read responses via an expected queue.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int E_W    = 16 + 2 + DATA_W;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              h_req, h_we, h_lock;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt, h_rvalid;
    logic [DATA_W-1:0] h_rdata;
    logic              d_req, d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt, i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    arb_state_t        dbg_state;

    logic [DATA_W-1:0] mem_model [2**ADDR_W];
    logic [DATA_W-1:0] exp_mem   [2**ADDR_W];
    logic [E_W-1:0]    exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Clock / reset-independent environment: clock, cycle counter, RAM model.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] gvec(input req_id_t w);
        case (w)
            REQ_H:   return 3'b100;
            REQ_D:   return 3'b010;
            REQ_I:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    // Sample one cycle: check grant and memory bus, model writes, queue expected reads.
    task automatic sample(input req_id_t exp_w, input bit push);
        logic              en, we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        @(negedge clock);
        en = 1'b1; we = 1'b0; addr = '0; wd = '0;
        case (exp_w)
            REQ_H:   begin we = h_we; addr = h_addr; wd = h_wdata; end
            REQ_D:   begin we = d_we; addr = d_addr; wd = d_wdata; end
            REQ_I:   begin addr = i_addr; end
            default: en = 1'b0;
        endcase
        check_eq("gnt_hdi", {61'd0, h_gnt, d_gnt, i_gnt}, {61'd0, gvec(exp_w)});
        check_eq("mem_en_we", {62'd0, mem_en, mem_we}, {62'd0, en, we});
        check_eq("mem_addr", 64'(mem_addr), 64'(addr));
        if (we || !en) check_eq("mem_wdata", 64'(mem_wdata), 64'(wd));
        if (en && we) exp_mem[addr] = wd;
        if (en && !we && push) exp_q.push_back({16'(cyc + 1), exp_w, exp_mem[addr]});
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ctl", {56'd0, h_gnt, d_gnt, i_gnt, h_rvalid, d_rvalid, i_rvalid, mem_en, mem_we}, 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_rdata", 64'(h_rdata | d_rdata | i_rdata), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'(ST_OPEN));
    endtask

    // Response monitor: exactly the queued owner pulses rvalid, one cycle after its grant.
    always @(negedge clock) begin
        logic [E_W-1:0]    e;
        logic [2:0]        rv;
        logic [DATA_W-1:0] rd;
        rv = {h_rvalid, d_rvalid, i_rvalid};
        if (exp_q.size() > 0 && exp_q[0][E_W-1:E_W-16] == 16'(cyc)) begin
            e = exp_q.pop_front();
            case (req_id_t'(e[DATA_W+1:DATA_W]))
                REQ_H:   rd = h_rdata;
                REQ_D:   rd = d_rdata;
                default: rd = i_rdata;
            endcase
            check_eq("rvalid_owner", {61'd0, rv}, {61'd0, gvec(req_id_t'(e[DATA_W+1:DATA_W]))});
            check_eq("rdata", 64'(rd), 64'(e[DATA_W-1:0]));
        end else begin
            check_eq("no_rvalid", {61'd0, rv}, 64'd0);
        end
    end

    initial begin
        for (int k = 0; k < 2**ADDR_W; k++) begin
            mem_model[k] = DATA_W'(k);
            exp_mem[k]   = DATA_W'(k);
        end
        reset_n = 1'b0;
        h_req = 0; h_we = 0; h_lock = 0; h_addr = '0; h_wdata = '0;
        d_req = 1; d_we = 0; d_addr = 7'd5; d_wdata = '0;
        i_req = 1; i_addr = 7'd9;
        repeat (2) begin
            @(negedge clock);
            check_reset_outputs();
        end
        advance();
        reset_n = 1'b1;

        // D/I tie from reset: I first, then alternate.
        for (int k = 0; k < 6; k++) begin
            sample((k % 2 == 0) ? REQ_I : REQ_D, 1'b1);
            advance();
        end
        d_req = 0; i_req = 0;
        sample(REQ_NONE, 1'b1);
        advance();

        // Host priority write, then D reads it back.
        h_req = 1; h_we = 1; h_addr = 7'd3; h_wdata = 32'hDEADBEEF;
        d_req = 1; i_req = 1;
        sample(REQ_H, 1'b1);
        advance();
        h_req = 0; h_we = 0; i_req = 0; d_addr = 7'd3;
        sample(REQ_D, 1'b1);
        advance();
        d_req = 0;
        sample(REQ_NONE, 1'b1);
        advance();

        // Lock and release.
        h_req = 1; h_lock = 1; h_addr = 7'd7; d_req = 1; d_addr = 7'd10;
        sample(REQ_H, 1'b1);
        advance();
        h_req = 0;
        repeat (4) begin
            sample(REQ_NONE, 1'b1);
            check_eq("lock_state", 64'(dbg_state), 64'(ST_LOCKED));
            advance();
        end
        h_lock = 0;
        sample(REQ_NONE, 1'b1);
        advance();
        sample(REQ_D, 1'b1);
        check_eq("unlock_state", 64'(dbg_state), 64'(ST_OPEN));
        advance();
        d_req = 0;

        // Starvation override under a continuous locked host burst.
        h_req = 1; h_lock = 1; h_we = 1; h_addr = 7'd20; h_wdata = $urandom;
        sample(REQ_H, 1'b1);
        advance();
        i_req = 1; i_addr = 7'd9;
        repeat (8) begin
            h_wdata = $urandom;
            sample(REQ_H, 1'b1);
            advance();
        end
        sample(REQ_I, 1'b1);
        check_eq("starve_state", 64'(dbg_state), 64'(ST_LOCKED));
        advance();
        i_req = 0;
        sample(REQ_H, 1'b1);
        check_eq("post_starve_state", 64'(dbg_state), 64'(ST_LOCKED));
        advance();
        h_req = 0; h_we = 0; h_lock = 0;
        sample(REQ_NONE, 1'b1);
        advance();
        sample(REQ_NONE, 1'b1);
        check_eq("release_state", 64'(dbg_state), 64'(ST_OPEN));
        advance();

        // Reset right after a D read grant: the response must be dropped.
        d_req = 1; d_addr = 7'd5;
        sample(REQ_D, 1'b0);
        reset_n = 1'b0;
        i_req = 1; i_addr = 7'd9;
        repeat (2) begin
            @(negedge clock);
            check_reset_outputs();
        end
        advance();
        reset_n = 1'b1;
        sample(REQ_I, 1'b1);
        advance();
        sample(REQ_D, 1'b1);
        advance();
        d_req = 0; i_req = 0;
        sample(REQ_NONE, 1'b1);
        advance();
        sample(REQ_NONE, 1'b1);
        advance();

        @(negedge clock);
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
